lsu_split_mc: RTL and testbench

- Multi-cycle load/store unit. It sits between the execute stage and a handshaked data-memory port.
- Generalises the combinational byte-lane LSU:
  - parametrised datapath width (XLEN 32/64);
  - registered request/response handshake;
  - one-outstanding memory protocol (req/gnt/rvalid);
  - hardware splitting of misaligned accesses into two aligned beats, or reporting them as errors.
- Loads return sign/zero-extended data. Stores drive byte enables.

---
 rtl/lsu_split_mc.sv | 182 ++++++++++++++++++
 tb/tb_lsu_split_mc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_split_mc.sv
// rtl/lsu_split_mc.sv - multi-cycle load/store unit with misaligned-access splitting
module lsu_split_mc #(
  parameter int XLEN     = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, ERR, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
  state_t state;

  logic            store_q, split_q;
  logic [2:0]      funct3_q;
  logic [OW-1:0]   off_q;
  logic [XLEN-1:0] base_q, wdata1_q, beat0_q, beat1_q;
  logic [NB-1:0]   be1_q;

  logic [OW-1:0]     off;
  logic [3:0]        size;
  logic              legal, misaligned;
  logic [NB-1:0]     size_mask;
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wdata_wide;
  logic [XLEN-1:0]   base;

  assign off        = req_addr[OW-1:0];
  assign size       = 4'd1 << req_funct3[1:0];
  assign base       = {req_addr[XLEN-1:OW], {OW{1'b0}}};
  assign misaligned = (5'(off) + 5'(size)) > 5'(NB);

  always_comb begin
    legal = 1'b0;
    if (req_store)
      legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11 || XLEN == 64);
    else
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (XLEN == 64);
        default:                                legal = 1'b0;
      endcase
  end

  // Both beats come from one double-width shift: low half is beat 0, high half beat 1.
  always_comb begin
    size_mask = '0;
    for (int i = 0; i < NB; i++) size_mask[i] = (i < int'(size));
  end
  assign be_wide    = {{NB{1'b0}}, size_mask} << off;
  assign wdata_wide = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};

  logic [XLEN-1:0] raw, load_ext;
  logic            sign;
  assign raw = XLEN'({beat1_q, beat0_q} >> {off_q, 3'b000});

  always_comb begin
    case (funct3_q[1:0])
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[XLEN-1];
    endcase
    sign     = sign & ~funct3_q[2];
    load_ext = '0;
    for (int i = 0; i < XLEN; i++) load_ext[i] = (i < (8 << funct3_q[1:0])) ? raw[i] : sign;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      store_q    <= 1'b0;
      split_q    <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      base_q     <= '0;
      wdata1_q   <= '0;
      be1_q      <= '0;
      beat0_q    <= '0;
      beat1_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            store_q   <= req_store;
            split_q   <= misaligned;
            funct3_q  <= req_funct3;
            off_q     <= off;
            base_q    <= base;
            wdata1_q  <= wdata_wide[2*XLEN-1:XLEN];
            be1_q     <= be_wide[2*NB-1:NB];
            beat1_q   <= '0;
            if (!legal || (misaligned && !SPLIT_EN)) begin
              state <= ERR;
            end else begin
              state     <= REQ0;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= base;
              mem_be    <= be_wide[NB-1:0];
              mem_wdata <= wdata_wide[XLEN-1:0];
            end
          end
        end
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          state      <= IDLE;
        end
        REQ0, REQ1: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            state     <= (state == REQ0) ? WAIT0 : WAIT1;
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            beat0_q <= mem_rdata;
            if (split_q) begin
              state     <= REQ1;
              mem_req   <= 1'b1;
              mem_we    <= store_q;
              mem_addr  <= base_q + XLEN'(NB);
              mem_be    <= be1_q;
              mem_wdata <= wdata1_q;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            beat1_q <= mem_rdata;
            state   <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b1;
          resp_rdata <= store_q ? '0 : load_ext;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_split_mc.sv
// tb/tb_lsu_split_mc.sv - bench for lsu_split_mc with a byte-level reference memory model
module tb_lsu_split_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;  // 0 selects the splitting unit, 1 the non-splitting unit
  logic        req_valid, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        a_ready, a_rv, a_err, a_mreq, a_we, b_ready, b_rv, b_err, b_mreq, b_we;
  logic [31:0] a_rdata, a_maddr, a_mwdata, b_rdata, b_maddr, b_mwdata;
  logic [3:0]  a_be, b_be;

  logic        req_ready, resp_valid, resp_err, mreq, mwe;
  logic [31:0] resp_rdata, maddr, mwdata;
  logic [3:0]  mbe;

  assign req_ready  = sel ? b_ready  : a_ready;
  assign resp_valid = sel ? b_rv     : a_rv;
  assign resp_err   = sel ? b_err    : a_err;
  assign resp_rdata = sel ? b_rdata  : a_rdata;
  assign mreq       = sel ? b_mreq   : a_mreq;
  assign mwe        = sel ? b_we     : a_we;
  assign maddr      = sel ? b_maddr  : a_maddr;
  assign mbe        = sel ? b_be     : a_be;
  assign mwdata     = sel ? b_mwdata : a_mwdata;

  lsu_split_mc #(.XLEN(32), .SPLIT_EN(1'b1)) u_split (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err),
    .mem_req(a_mreq), .mem_gnt(mem_gnt & ~sel), .mem_we(a_we), .mem_addr(a_maddr), .mem_be(a_be),
    .mem_wdata(a_mwdata), .mem_rvalid(mem_rvalid & ~sel), .mem_rdata(mem_rdata));

  lsu_split_mc #(.XLEN(32), .SPLIT_EN(1'b0)) u_nosplit (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err),
    .mem_req(b_mreq), .mem_gnt(mem_gnt & sel), .mem_we(b_we), .mem_addr(b_maddr), .mem_be(b_be),
    .mem_wdata(b_mwdata), .mem_rvalid(mem_rvalid & sel), .mem_rdata(mem_rdata));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder memory and an independent reference memory, both seeded from the same pattern.
  logic [7:0] mem [int unsigned];
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] init_byte(input int unsigned a);
    return 8'(a * 37 + 90);
  endfunction
  function automatic logic [7:0] mem_rd(input int unsigned a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction
  task automatic set_byte(input int unsigned a, input logic [7:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;
  beat_t log_q[$];

  int          gnt_delay = 0, rv_delay = 0, gcnt = 0, rcnt = 0;
  bit          rv_pend = 0, hold = 0;
  logic [31:0] rd_hold, snap_addr;
  logic [36:0] snap_ctl;

  always @(negedge clk) begin
    beat_t b;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (!rst_n) begin
      rv_pend = 0;
      hold    = 0;
      gcnt    = 0;
    end else if (rv_pend) begin
      if (rcnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_hold;
        rv_pend    = 0;
      end else rcnt--;
    end else if (mreq) begin
      if (hold) begin
        check("hold_addr", 64'(maddr), 64'(snap_addr));
        check("hold_ctl", 64'({mwe, mbe, mwdata}), 64'(snap_ctl));
      end
      if (gcnt >= gnt_delay) begin
        mem_gnt = 1'b1;
        gcnt    = 0;
        hold    = 0;
        b.addr = maddr; b.be = mbe; b.we = mwe; b.wdata = mwdata;
        log_q.push_back(b);
        rd_hold = '0;
        for (int i = 0; i < 4; i++) begin
          if (mwe && mbe[i]) mem[maddr + i] = mwdata[8*i +: 8];
          rd_hold[8*i +: 8] = mem_rd(maddr + i);
        end
        rv_pend = 1;
        rcnt    = rv_delay;
      end else begin
        gcnt++;
        hold      = 1;
        snap_addr = maddr;
        snap_ctl  = {mwe, mbe, mwdata};
      end
    end
  end

  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int          s, nbeats, lat, k;
    bit          legal, mis, err, timeout, ready_seen;
    logic [63:0] v;
    logic [31:0] exp_rd, b;
    logic [3:0]  exp_be [2];
    s      = 1 << f3[1:0];
    legal  = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis    = (a % 4) + s > 4;
    err    = !legal || (mis && sel);
    nbeats = err ? 0 : (mis ? 2 : 1);
    exp_be = '{4'b0, 4'b0};
    v      = '0;
    if (!err) begin
      for (int i = 0; i < s; i++) begin
        b = a + i;
        exp_be[(b / 4) - (a / 4)][b % 4] = 1'b1;
        v |= 64'(ref_rd(b)) << (8 * i);
        if (st) ref_mem[b] = wd[8*i +: 8];
      end
    end
    if (!f3[2] && s < 4 && v[8*s-1]) v |= ~((64'd1 << (8 * s)) - 64'd1);
    exp_rd = (err || st) ? 32'd0 : v[31:0];

    log_q.delete();
    timeout = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin timeout = 0; break; end
    end
    check("ready_wait", 64'(timeout), 64'd0);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;

    lat = 0; timeout = 1; ready_seen = 0;
    repeat (200) begin
      @(negedge clk);
      lat++;
      if (req_ready) ready_seen = 1;
      if (resp_valid) begin timeout = 0; break; end
    end
    check("resp_timeout", 64'(timeout), 64'd0);
    if (!timeout) begin
      check("resp_err", 64'(resp_err), 64'(err));
      check("resp_rdata", 64'(resp_rdata), 64'(exp_rd));
      check("ready_busy", 64'(ready_seen), 64'd0);
      if (gnt_delay == 0 && rv_delay == 0) check("latency", 64'(lat), 64'(2 + 2 * nbeats));
      check("beats", 64'(log_q.size()), 64'(nbeats));
      for (int j = 0; j < nbeats && j < log_q.size(); j++) begin
        check("beat_be", 64'(log_q[j].be), 64'(exp_be[j]));
        check("beat_addr", 64'(log_q[j].addr), 64'(((a / 4) + j) * 4));
        check("beat_we", 64'(log_q[j].we), 64'(st));
      end
      if (st && !err) begin
        for (int i = 0; i < s; i++) begin
          b = a + i;
          k = (b / 4) - (a / 4);
          if (k < log_q.size()) check("store_lane", 64'(log_q[k].wdata[8*(b%4) +: 8]), 64'(wd[8*i +: 8]));
        end
      end
      @(negedge clk);
      check("resp_pulse", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
      check("ready_after", 64'(req_ready), 64'd1);
    end
  endtask

  initial begin
    int   n;
    bit   timeout, rv_seen;
    sel = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
    check("rst_mem", 64'({mreq, mwe, mbe, maddr}), 64'd0);
    check("rst_wdata", 64'(mwdata), 64'd0);
    rst_n = 1'b1;

    set_byte(32'h100, 8'hEF); set_byte(32'h101, 8'hBE); set_byte(32'h102, 8'hAD); set_byte(32'h103, 8'hDE);
    do_txn(1'b0, 3'b010, 32'h100, 32'h0);
    set_byte(32'h103, 8'h80);
    do_txn(1'b0, 3'b000, 32'h103, 32'h0);
    do_txn(1'b0, 3'b100, 32'h103, 32'h0);
    do_txn(1'b1, 3'b001, 32'h102, 32'h1234ABCD);
    set_byte(32'h101, 8'h11); set_byte(32'h102, 8'h22); set_byte(32'h103, 8'h33); set_byte(32'h104, 8'h44);
    do_txn(1'b0, 3'b010, 32'h101, 32'h0);
    do_txn(1'b1, 3'b010, 32'h0FE, 32'hCAFEF00D);
    do_txn(1'b0, 3'b010, 32'h0FE, 32'h0);

    sel = 1'b1;
    do_txn(1'b1, 3'b010, 32'h102, 32'h55667788);
    do_txn(1'b0, 3'b010, 32'h108, 32'h0);
    sel = 1'b0;
    do_txn(1'b0, 3'b011, 32'h100, 32'h0);
    do_txn(1'b1, 3'b100, 32'h100, 32'h0);

    gnt_delay = 5;
    do_txn(1'b0, 3'b010, 32'h101, 32'h0);
    do_txn(1'b1, 3'b001, 32'h107, 32'hBEEF1234);
    gnt_delay = 0;

    // Reset while the unit waits for read data; the access must vanish without a response.
    rv_delay = 3;
    log_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    timeout = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (log_q.size() == 1) begin timeout = 0; break; end
    end
    check("rst_gnt_wait", 64'(timeout), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", 64'(req_ready), 64'd1);
    rv_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) rv_seen = 1;
    end
    check("midrst_no_resp", 64'(rv_seen), 64'd0);
    rv_delay = 0;
    do_txn(1'b0, 3'b010, 32'h100, 32'h0);

    for (n = 0; n < 150; n++) begin
      sel = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        gnt_delay = 0; rv_delay = 0;
      end else begin
        gnt_delay = $urandom_range(0, 3); rv_delay = $urandom_range(0, 3);
      end
      do_txn(1'($urandom), 3'($urandom_range(0, 7)), 32'h200 + $urandom_range(0, 31), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
